// File: rtl/n64_joybus_pkg.sv
// n64_joybus_pkg: command codes, FSM states and wire timing shared by the joybus device
package n64_joybus_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_STOP, TURNAROUND, TX_BITS, TX_STOP, RECOVER
  } state_t;

  localparam int RX_BIT_THRESH_US = 2;
  localparam int RX_LOW_MAX_US    = 5;
  localparam int RX_HIGH_MAX_US   = 8;
  localparam int TX_CELL_US       = 4;
  localparam int TX_ONE_LOW_US    = 1;
  localparam int TX_ZERO_LOW_US   = 3;
  localparam int TX_STOP_LOW_US   = 2;

endpackage

// File: rtl/n64_joybus_rx_sync.sv
// n64_joybus_rx_sync: two-flop synchroniser for the joybus line with rise/fall detect
module n64_joybus_rx_sync (
  input  logic i_sample_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;
  // Flops reset low so a line that is already low after reset yields no fall until it has been high
  always_ff @(posedge i_sample_clk or negedge i_rst_n)
    if (!i_rst_n) {r_meta, r_sync, r_prev} <= 3'b000;
    else          {r_meta, r_sync, r_prev} <= {i_data, r_meta, r_sync};
  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;
endmodule

// File: rtl/n64_joybus_device.sv
// n64_joybus_device: joybus controller endpoint decoding console commands and sending status/poll replies
import n64_joybus_pkg::*;

module n64_joybus_device #(
  parameter int          CLK_PER_US    = 4,
  parameter logic [15:0] DEVICE_ID     = 16'h0500,
  parameter logic [7:0]  DEVICE_STATUS = 8'h02,
  parameter int          TURNAROUND_US = 2,
  parameter int          IDLE_US       = 8
) (
  input  logic        i_sample_clk,
  input  logic        i_rst_n,
  input  logic        i_data_rx,
  input  logic [15:0] i_button_state,
  input  logic [7:0]  i_stick_x,
  input  logic [7:0]  i_stick_y,
  output logic        o_data_tx,
  output logic        o_data_oe,
  output logic        o_cur_operation,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  output logic        o_rx_error
);
  localparam int MAX_US    = IDLE_US > RX_HIGH_MAX_US ? (IDLE_US > TURNAROUND_US ? IDLE_US : TURNAROUND_US)
                                                      : (RX_HIGH_MAX_US > TURNAROUND_US ? RX_HIGH_MAX_US : TURNAROUND_US);
  localparam int TIM_MAX_I = MAX_US * CLK_PER_US;
  localparam int TW        = $clog2(TIM_MAX_I + 1);
  localparam logic [TW-1:0] C_ONE      = TW'(1);
  localparam logic [TW-1:0] C_TIM_MAX  = TW'(TIM_MAX_I);
  localparam logic [TW-1:0] C_THRESH   = TW'(RX_BIT_THRESH_US * CLK_PER_US);
  localparam logic [TW-1:0] C_LOW_MAX  = TW'(RX_LOW_MAX_US * CLK_PER_US);
  localparam logic [TW-1:0] C_HIGH_MAX = TW'(RX_HIGH_MAX_US * CLK_PER_US);
  localparam logic [TW-1:0] C_TA_LAST  = TW'(TURNAROUND_US * CLK_PER_US - 1);
  localparam logic [TW-1:0] C_IDLE_END = TW'(IDLE_US * CLK_PER_US - 1);
  localparam logic [TW-1:0] C_CELL_END = TW'(TX_CELL_US * CLK_PER_US - 1);
  localparam logic [TW-1:0] C_ONE_LOW  = TW'(TX_ONE_LOW_US * CLK_PER_US);
  localparam logic [TW-1:0] C_ZERO_LOW = TW'(TX_ZERO_LOW_US * CLK_PER_US);
  localparam logic [TW-1:0] C_STOP_LOW = TW'(TX_STOP_LOW_US * CLK_PER_US);

  state_t        r_state, w_state;
  logic [TW-1:0] r_tim, w_tim, w_tim_inc, w_low_len;
  logic [5:0]    r_bit, w_bit;
  logic [7:0]    r_rx, w_rx, r_cmd, w_cmd;
  logic [31:0]   r_tx, w_tx;
  logic          r_cv, w_cv, r_err, w_err, r_dtx, w_dtx, r_oe, w_oe;
  logic          w_level, w_rise, w_fall, w_timeout, w_poll, w_stat;

  n64_joybus_rx_sync u_sync (
    .i_sample_clk (i_sample_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data_rx),
    .o_level      (w_level),
    .o_rise       (w_rise),
    .o_fall       (w_fall)
  );

  assign w_tim_inc = (r_tim == C_TIM_MAX) ? r_tim : r_tim + C_ONE;
  assign w_timeout = ~w_rise & ~w_fall & (w_level ? r_tim >= C_HIGH_MAX : r_tim >= C_LOW_MAX);
  assign w_poll    = r_rx == CMD_POLL;
  assign w_stat    = (r_rx == CMD_STATUS) || (r_rx == CMD_RESET);
  assign w_low_len = w_tx[31] ? C_ONE_LOW : C_ZERO_LOW;
  assign w_oe      = (w_state == TX_BITS) || (w_state == TX_STOP);
  assign w_dtx     = (w_state == TX_BITS) ? (w_tim >= w_low_len) :
                     (w_state == TX_STOP) ? (w_tim >= C_STOP_LOW) : 1'b1;

  // Next-state and datapath: RX decode by low-time, reply snapshot at the stop edge, TX cell timing
  always_comb begin
    w_state = r_state;
    w_tim   = r_tim;
    w_bit   = r_bit;
    w_rx    = r_rx;
    w_tx    = r_tx;
    w_cmd   = r_cmd;
    w_cv    = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (w_fall) begin
        w_state = RX_BITS;
        w_tim   = C_ONE;
        w_bit   = '0;
      end
      RX_BITS, RX_STOP: begin
        if (w_timeout) begin
          w_state = RECOVER;
          w_tim   = '0;
          w_err   = 1'b1;
        end else if (w_fall) w_tim = C_ONE;
        else if (w_rise && r_state == RX_BITS) begin
          w_tim = C_ONE;
          w_rx  = {r_rx[6:0], r_tim < C_THRESH};
          w_bit = r_bit + 6'd1;
          if (r_bit == 6'd7) begin
            w_state = RX_STOP;
            w_bit   = '0;
          end
        end else if (w_rise) begin
          w_cmd   = r_rx;
          w_cv    = 1'b1;
          w_state = (w_poll || w_stat) ? TURNAROUND : RECOVER;
          w_tim   = (w_poll || w_stat) ? '0 : C_ONE;
          w_tx    = w_poll ? {i_button_state, i_stick_x, i_stick_y} :
                    w_stat ? {DEVICE_ID, DEVICE_STATUS, 8'h00} : r_tx;
          w_bit   = w_poll ? 6'd32 : w_stat ? 6'd24 : 6'd0;
        end else w_tim = w_tim_inc;
      end
      TURNAROUND: begin
        w_state = (r_tim == C_TA_LAST) ? TX_BITS : TURNAROUND;
        w_tim   = (r_tim == C_TA_LAST) ? '0 : w_tim_inc;
      end
      TX_BITS: if (r_tim == C_CELL_END) begin
        w_tim   = '0;
        w_tx    = {r_tx[30:0], 1'b0};
        w_bit   = r_bit - 6'd1;
        w_state = (r_bit == 6'd1) ? TX_STOP : TX_BITS;
      end else w_tim = w_tim_inc;
      TX_STOP: begin
        w_state = (r_tim == C_STOP_LOW) ? IDLE : TX_STOP;
        w_tim   = (r_tim == C_STOP_LOW) ? '0 : w_tim_inc;
      end
      RECOVER: begin
        w_state = (w_level && r_tim >= C_IDLE_END) ? IDLE : RECOVER;
        w_tim   = (!w_level || r_tim >= C_IDLE_END) ? '0 : w_tim_inc;
      end
      default: w_state = IDLE;
    endcase
  end

  // State and registered outputs; reset releases the line at once
  always_ff @(posedge i_sample_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_tim   <= '0;
      r_bit   <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_cmd   <= 8'h00;
      r_cv    <= 1'b0;
      r_err   <= 1'b0;
      r_dtx   <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tim   <= w_tim;
      r_bit   <= w_bit;
      r_rx    <= w_rx;
      r_tx    <= w_tx;
      r_cmd   <= w_cmd;
      r_cv    <= w_cv;
      r_err   <= w_err;
      r_dtx   <= w_dtx;
      r_oe    <= w_oe;
    end

  assign o_data_tx       = r_dtx;
  assign o_data_oe       = r_oe;
  assign o_cur_operation = r_oe;
  assign o_cmd           = r_cmd;
  assign o_cmd_valid     = r_cv;
  assign o_rx_error      = r_err;
endmodule
